// File: rtl/op_skew_pipe_if.sv
// Operand skew pipe bus: control, input vector and skewed output vector.
// clk and clr_n stay outside as plain ports.
interface op_skew_pipe_if #(
  parameter int WIDTH = 16,
  parameter int LANES = 4
);
  logic                   en;
  logic                   flush;
  logic                   in_valid;
  logic                   in_last;
  logic [LANES*WIDTH-1:0] in_data;
  logic [LANES-1:0]       out_valid;
  logic [LANES*WIDTH-1:0] out_data;
  logic                   busy;
  logic                   done;

  modport master (
    output en,
    output flush,
    output in_valid,
    output in_last,
    output in_data,
    input  out_valid,
    input  out_data,
    input  busy,
    input  done
  );

  modport slave (
    input  en,
    input  flush,
    input  in_valid,
    input  in_last,
    input  in_data,
    output out_valid,
    output out_data,
    output busy,
    output done
  );
endinterface

// File: rtl/op_skew_pipe.sv
// Diagonal operand skew for a systolic array edge.
// Lane i delays its operand by i+1 enabled clocks.
module op_skew_pipe #(
  parameter int WIDTH = 16,
  parameter int LANES = 4
) (
  input  logic           clk,
  input  logic           clr_n,
  op_skew_pipe_if.slave  p
);

  logic [LANES-1:0]       vany;
  logic [LANES-1:0]       oval;
  logic [LANES*WIDTH-1:0] odat;
  logic                   fire;
  logic                   done_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [WIDTH-1:0] d_q [i+1];
    logic [WIDTH-1:0] d_d [i+1];
    logic [i:0]       v_q;
    logic [i:0]       v_d;

    // Bubbles enter as zero data so downstream MACs add nothing.
    always_comb begin
      d_d[0] = p.in_valid ? p.in_data[i*WIDTH +: WIDTH] : '0;
      v_d[0] = p.in_valid;
      for (int j = 1; j <= i; j++) begin
        d_d[j] = d_q[j-1];
        v_d[j] = v_q[j-1];
      end
    end

    always_ff @(posedge clk) begin
      if (!clr_n || p.flush) begin
        for (int j = 0; j <= i; j++) begin
          d_q[j] <= '0;
        end
        v_q <= '0;
      end else if (p.en) begin
        d_q <= d_d;
        v_q <= v_d;
      end
    end

    assign odat[i*WIDTH +: WIDTH] = d_q[i];
    assign oval[i]                = v_q[i];
    assign vany[i]                = |v_q;

    // Only the tail lane's last tag is observable, via done.
    if (i == LANES-1) begin : g_tail
      if (i == 0) begin : g_one
        assign fire = p.en & p.in_valid & p.in_last;
      end else begin : g_chain
        logic [i-1:0] l_q;

        always_ff @(posedge clk) begin
          if (!clr_n || p.flush) begin
            l_q <= '0;
          end else if (p.en) begin
            l_q[0] <= p.in_valid & p.in_last;
            for (int j = 1; j < i; j++) begin
              l_q[j] <= l_q[j-1];
            end
          end
        end

        assign fire = p.en & v_d[i] & l_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n || p.flush) begin
      done_q <= 1'b0;
    end else begin
      done_q <= fire;
    end
  end

  assign p.out_valid = oval;
  assign p.out_data  = odat;
  assign p.busy      = |vany;
  assign p.done      = done_q;

endmodule

// File: doc/op_skew_pipe.md
Name: op_skew_pipe

Overview:
- Parametrised successor to the single-lane operand-2 PIPO register.
- Takes one vector of LANES operands per cycle and delays lane i by i+1 clocks. This produces the diagonal skew that feeds the next row or column of the systolic array.
- A valid bit and a last tag travel with the data. Stall (en), flush and a busy/done indication are provided for the array controller.

Parameters:
WIDTH, 16, bit width of each operand lane
LANES, 4, number of lanes (>=1); lane i latency = i+1 enabled cycles; total storage LANES*(LANES+1)/2 stages

Ports:
clk  input  1  rising-edge clock
clr_n  input  1  synchronous active-low reset
en  input  1  advance enable; 0 = hold every stage
flush  input  1  synchronous clear of pipeline contents, active-high
in_valid  input  1  in_data vector is valid this cycle
in_last  input  1  marks the final vector of a tile
in_data  input  LANES*WIDTH  lane i = in_data[i*WIDTH +: WIDTH]
out_valid  output  LANES  per-lane valid at skewed output
out_data  output  LANES*WIDTH  lane i = out_data[i*WIDTH +: WIDTH]
busy  output  1  any stage holds a valid entry
done  output  1  one-cycle pulse when lane LANES-1 emits a valid last entry

Behaviour:
- Reset and clear:
  - Reset is synchronous. clr_n=0 at a clk edge clears all stage data to 0, all valid and last bits to 0, and done to 0.
  - clr_n has priority over flush and en.
  - Reset mid-stream discards all in-flight entries. No partial output follows.
- Flush: clr_n=1 and flush=1 gives the same clearing effect as reset in one cycle, regardless of en. The input accepted in that cycle is discarded.
- Stage structure:
  - Lane i is a chain of i+1 registers {data, valid, last}. All outputs are registered.
  - out_data lane i and out_valid[i] come from the last register of chain i.
- Advance (en=1, no clear/flush):
  - Every register takes its predecessor's value.
  - Stage 0 of each lane i loads in_data lane i, in_valid and in_last.
  - If in_valid=0, stage 0 loads data 0 and last 0. Bubbles are zero data, so downstream MACs accumulate nothing.
- Hold (en=0): every register keeps its value, and input is ignored. done is forced to 0 during hold so that it pulses exactly once.
- Latency:
  - A vector accepted at edge k appears on lane i after edge k+i, i.e. visible in cycle k+i+1.
  - The vector is complete on lane LANES-1 after LANES enabled edges. Only enabled edges count.
- done: registered. It is set on the edge where the lane LANES-1 final stage is loaded with valid=1 and last=1 under en=1. It clears on the next edge.
- busy: combinational OR of all valid bits in all stages. It deasserts once the final entry leaves lane LANES-1.
- Invariant: out_data lane i = 0 whenever out_valid[i] = 0.
- Back-to-back valid vectors at full rate are supported with no gaps. Throughput is one vector per enabled cycle.
- LANES=1 degenerates to a single registered lane with valid/last, equivalent to the predecessor PIPO plus tagging.
- No arithmetic is done; data passes bit-exact with no width change.

Test Plan:
- Reset: drive clr_n=0 for 2 cycles with in_valid=1, in_data=all 16'hFFFF -> out_data=0, out_valid=4'b0000, busy=0, done=0.
- Skew:
  - Stimulus: LANES=4. Drive in_valid=1 for one cycle with lanes {0x000A,0x000B,0x000C,0x000D} and in_last=1, en=1 throughout.
  - Response: lane0=0x000A valid at cycle+1, lane1=0x000B at +2, lane2=0x000C at +3, lane3=0x000D at +4 with done=1 for exactly that cycle. Each lane shows 0 with valid=0 at all other times. busy falls after +4.
- Stall: as in the skew case, but drop en for 3 cycles after the second edge -> all outputs frozen during the stall. Lane3 emits at +7 and done pulses once.
- Streaming: 5 consecutive vectors, lane0 values 1..5 (in_last=1 on the 5th) -> lane0 outputs 1,2,3,4,5 on consecutive cycles with no bubbles. done fires once, on the cycle lane3 emits the 5th vector.
- Flush mid-stream: flush=1 two cycles after injecting 3 vectors -> next cycle all out_valid=0, out_data=0, busy=0. No later output and no done.
- Priority: clr_n=0 and flush=1 together with en=0 -> everything cleared. Release clr_n, and a vector injected the following cycle emerges with normal latency.
